// File: rtl/mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mode_scheduler
// Description : Grants one traffic-light mode at a time, confirms the handoff
//               through its feedback handshake, and muxes its light out.
// Revision    : 1.0 - initial release
// ============================================================================
module mode_scheduler #(
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] feedback,
    input  logic [5:0] mode_light,
    output logic [2:0] enb,
    output logic [1:0] last_state,
    output logic [1:0] light,
    output logic [1:0] active_mode,
    output logic       fault
);

    localparam int              CW          = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0]   c_timeout   = CW'(ACK_TIMEOUT);
    localparam logic [CW-1:0]   c_cnt_one   = CW'(1);

    localparam logic [1:0]      c_st_idle    = 2'd0;
    localparam logic [1:0]      c_st_grant   = 2'd1;
    localparam logic [1:0]      c_st_run     = 2'd2;
    localparam logic [1:0]      c_st_release = 2'd3;

    localparam logic [1:0]      c_mode_auto   = 2'b00;
    localparam logic [1:0]      c_mode_manual = 2'b01;
    localparam logic [1:0]      c_mode_online = 2'b10;
    localparam logic [1:0]      c_mode_none   = 2'b11;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [1:0]    r_sel;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_light;
    logic [1:0]    r_last_state;
    logic          r_fault;
    logic [2:0]    r_dead;

    logic [2:0]    w_eligible;
    logic [1:0]    w_winner;
    logic [2:0]    w_sel_onehot;
    logic [1:0]    w_sel_light;
    logic          w_sel_fb;
    logic          w_take_grant;
    logic          w_track_light;
    logic          w_capture;
    logic          w_set_fault;
    logic          w_mark_dead;

    assign light      = r_light;
    assign last_state = r_last_state;
    assign fault      = r_fault;

    // Fixed priority: online > manual > auto, dead modes excluded
    always_comb begin
        w_eligible = req & ~r_dead;
        w_winner   = c_mode_none;
        if (w_eligible[2])      w_winner = c_mode_online;
        else if (w_eligible[1]) w_winner = c_mode_manual;
        else if (w_eligible[0]) w_winner = c_mode_auto;
    end

    always_comb begin
        w_sel_onehot = 3'b000;
        w_sel_light  = 2'b00;
        case (r_sel)
            c_mode_auto: begin
                w_sel_onehot = 3'b001;
                w_sel_light  = mode_light[1:0];
            end
            c_mode_manual: begin
                w_sel_onehot = 3'b010;
                w_sel_light  = mode_light[3:2];
            end
            c_mode_online: begin
                w_sel_onehot = 3'b100;
                w_sel_light  = mode_light[5:4];
            end
            default: begin
                w_sel_onehot = 3'b000;
                w_sel_light  = 2'b00;
            end
        endcase
        w_sel_fb = |(feedback & w_sel_onehot);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        enb           = 3'b000;
        active_mode   = c_mode_none;
        w_take_grant  = 1'b0;
        w_track_light = 1'b0;
        w_capture     = 1'b0;
        w_set_fault   = 1'b0;
        w_mark_dead   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (|w_eligible) begin
                    w_next_state = c_st_grant;
                    w_take_grant = 1'b1;
                end
            end
            c_st_grant: begin
                enb = w_sel_onehot;
                // Acknowledge wins over a timeout landing in the same cycle
                if (w_sel_fb) begin
                    w_next_state  = c_st_run;
                    w_track_light = 1'b1;
                end else if (r_cnt == c_timeout) begin
                    w_next_state = c_st_idle;
                    w_set_fault  = 1'b1;
                    w_mark_dead  = 1'b1;
                end
            end
            c_st_run: begin
                enb         = w_sel_onehot;
                active_mode = r_sel;
                if (w_winner != r_sel) begin
                    w_next_state = c_st_release;
                    w_capture    = 1'b1;
                end else begin
                    w_track_light = 1'b1;
                end
            end
            default: begin
                if (!w_sel_fb) begin
                    w_next_state = c_st_idle;
                end else if (r_cnt == c_timeout) begin
                    w_next_state = c_st_idle;
                    w_set_fault  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel        <= c_mode_none;
            r_cnt        <= '0;
            r_light      <= 2'b00;
            r_last_state <= 2'b00;
            r_fault      <= 1'b0;
            r_dead       <= 3'b000;
        end else begin
            if (w_take_grant) r_sel <= w_winner;
            // Counter restarts on every state change and saturates at the limit
            if (w_next_state != r_state)  r_cnt <= '0;
            else if (r_cnt != c_timeout)  r_cnt <= r_cnt + c_cnt_one;
            if (w_track_light) r_light      <= w_sel_light;
            if (w_capture)     r_last_state <= r_light;
            if (w_set_fault)   r_fault      <= 1'b1;
            if (w_mark_dead)   r_dead       <= r_dead | w_sel_onehot;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode_scheduler
// Description : Directed self-checking bench for mode_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_scheduler;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] feedback;
    logic [5:0] mode_light;
    logic [2:0] enb;
    logic [1:0] last_state;
    logic [1:0] light;
    logic [1:0] active_mode;
    logic       fault;

    int n_tests = 0;
    int n_fail  = 0;

    mode_scheduler #(.ACK_TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .feedback    (feedback),
        .mode_light  (mode_light),
        .enb         (enb),
        .last_state  (last_state),
        .light       (light),
        .active_mode (active_mode),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        req        = 3'b111;
        feedback   = 3'b000;
        mode_light = 6'b01_01_10;
        step(2);
        chk("rst_enb",    int'(enb),         'b000);
        chk("rst_light",  int'(light),       'b00);
        chk("rst_active", int'(active_mode), 'b11);
        chk("rst_fault",  int'(fault),       0);
        chk("rst_last",   int'(last_state),  'b00);

        // Online wins after reset
        rst = 1'b0;
        step(1);
        chk("grant_online_enb", int'(enb), 'b100);
        feedback = 3'b100;
        step(1);
        chk("run_online_active", int'(active_mode), 'b10);
        chk("run_online_light",  int'(light),       'b01);
        mode_light[5:4] = 2'b10;
        step(1);
        chk("follow_light_a", int'(light), 'b10);
        mode_light[5:4] = 2'b01;
        step(1);
        chk("follow_light_b", int'(light), 'b01);

        // Online request drops -> release toward auto
        req = 3'b001;
        step(1);
        chk("rel_online_enb",  int'(enb),         'b000);
        chk("rel_online_last", int'(last_state),  'b01);
        chk("rel_online_lit",  int'(light),       'b01);
        chk("rel_online_act",  int'(active_mode), 'b11);
        feedback = 3'b000;
        step(1);
        chk("idle_enb", int'(enb), 'b000);
        step(1);
        chk("grant_auto_enb", int'(enb), 'b001);
        feedback = 3'b001;
        step(1);
        chk("run_auto_active", int'(active_mode), 'b00);
        chk("run_auto_light",  int'(light),       'b10);

        // Online preempts running auto
        req = 3'b101;
        step(1);
        chk("preempt_enb",  int'(enb),        'b000);
        chk("preempt_last", int'(last_state), 'b10);
        feedback = 3'b000;
        step(1);
        chk("preempt_idle_enb", int'(enb), 'b000);
        step(1);
        chk("preempt_grant_enb", int'(enb), 'b100);

        // Move to manual; auto request must not preempt it
        feedback = 3'b100;
        req      = 3'b010;
        step(1);
        chk("online_again_act", int'(active_mode), 'b10);
        step(1);
        feedback = 3'b000;
        step(2);
        chk("grant_manual_enb", int'(enb), 'b010);
        feedback = 3'b010;
        step(1);
        chk("run_manual_act",   int'(active_mode), 'b01);
        chk("run_manual_light", int'(light),       'b01);
        req = 3'b011;
        step(1);
        chk("noprmt_enb",   int'(enb),         'b010);
        chk("noprmt_act",   int'(active_mode), 'b01);
        chk("noprmt_light", int'(light),       'b01);

        // Release timeout: feedback stuck high
        req = 3'b001;
        step(1);
        chk("reltmo_c1_enb", int'(enb), 'b000);
        step(7);
        chk("reltmo_c8_fault", int'(fault), 0);
        chk("reltmo_c8_enb",   int'(enb),   'b000);
        step(2);
        chk("reltmo_fault", int'(fault), 1);
        chk("reltmo_enb",   int'(enb),   'b000);
        step(1);
        chk("reltmo_rearb_enb", int'(enb), 'b001);

        // Reset while auto is running
        feedback = 3'b001;
        step(1);
        chk("pre_rst_act",   int'(active_mode), 'b00);
        chk("pre_rst_light", int'(light),       'b10);
        rst = 1'b1;
        step(1);
        chk("midrst_enb",   int'(enb),         'b000);
        chk("midrst_light", int'(light),       'b00);
        chk("midrst_act",   int'(active_mode), 'b11);
        chk("midrst_fault", int'(fault),       0);
        chk("midrst_last",  int'(last_state),  'b00);

        // Grant timeout marks manual dead
        rst      = 1'b0;
        req      = 3'b010;
        feedback = 3'b000;
        step(1);
        chk("gtmo_c1_enb", int'(enb), 'b010);
        step(7);
        chk("gtmo_c8_enb",   int'(enb),   'b010);
        chk("gtmo_c8_fault", int'(fault), 0);
        step(2);
        chk("gtmo_fault", int'(fault), 1);
        chk("gtmo_enb",   int'(enb),   'b000);
        req = 3'b011;
        step(1);
        chk("dead_skip_enb", int'(enb), 'b001);

        // All requests drop during grant: finish handshake then release
        req = 3'b000;
        step(1);
        chk("drop_grant_enb", int'(enb), 'b001);
        feedback = 3'b001;
        step(1);
        chk("drop_run_act", int'(active_mode), 'b00);
        step(1);
        chk("drop_rel_enb", int'(enb),         'b000);
        chk("drop_rel_act", int'(active_mode), 'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
